// File: rtl/car_motion_ctrl.sv
// Elevator car motion FSM: travels one floor per FLOOR_TICKS cycles toward the
// comparator's verdict, opens the door on arrival, and flags illegal results/limits.
module car_motion_ctrl #(
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] result,
  input  logic       door_hold,
  output logic [2:0] now,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic       arrived,
  output logic       fault
);
  localparam int TW = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
  localparam int DW = (DOOR_TICKS  > 1) ? $clog2(DOOR_TICKS)  : 1;
  localparam logic [TW-1:0] T_LAST = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [DW-1:0] D_LOAD = DW'(DOOR_TICKS - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [2:0]    R_UP   = 3'b100;
  localparam logic [2:0]    R_EQ   = 3'b010;
  localparam logic [2:0]    R_DN   = 3'b001;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t        state, state_nx;
  logic [2:0]    now_nx;
  logic [TW-1:0] ttmr, ttmr_nx;
  logic [DW-1:0] dtmr, dtmr_nx;
  logic          fchk, fchk_nx;   // car is sitting at a floor awaiting a decision
  logic          arr_nx, flt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      now     <= '0;
      ttmr    <= '0;
      dtmr    <= '0;
      fchk    <= 1'b0;
      arrived <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_nx;
      now     <= now_nx;
      ttmr    <= ttmr_nx;
      dtmr    <= dtmr_nx;
      fchk    <= fchk_nx;
      arrived <= arr_nx;
      fault   <= flt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    now_nx   = now;
    ttmr_nx  = ttmr;
    dtmr_nx  = dtmr;
    fchk_nx  = fchk;
    arr_nx   = 1'b0;
    flt_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (result)
            R_UP: begin
              if (now == 3'd7) flt_nx = 1'b1;
              else begin
                state_nx = MOVE_UP;
                ttmr_nx  = '0;
                fchk_nx  = 1'b1;
              end
            end
            R_DN: begin
              if (now == 3'd0) flt_nx = 1'b1;
              else begin
                state_nx = MOVE_DOWN;
                ttmr_nx  = '0;
                fchk_nx  = 1'b1;
              end
            end
            R_EQ: begin
              state_nx = DOOR_OPEN;
              dtmr_nx  = D_LOAD;
              arr_nx   = 1'b1;
            end
            default: flt_nx = 1'b1;
          endcase
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (fchk && ttmr == '0) begin
          fchk_nx = 1'b0;
          if (!req_valid) state_nx = IDLE;
          else begin
            case (result)
              R_EQ: begin
                state_nx = DOOR_OPEN;
                dtmr_nx  = D_LOAD;
                arr_nx   = 1'b1;
              end
              R_UP: begin
                if (state == MOVE_DOWN) state_nx = IDLE;
                else if (now == 3'd7) begin
                  state_nx = IDLE;
                  flt_nx   = 1'b1;
                end else ttmr_nx = ttmr + T_ONE;
              end
              R_DN: begin
                if (state == MOVE_UP) state_nx = IDLE;
                else if (now == 3'd0) begin
                  state_nx = IDLE;
                  flt_nx   = 1'b1;
                end else ttmr_nx = ttmr + T_ONE;
              end
              default: begin
                state_nx = IDLE;
                flt_nx   = 1'b1;
              end
            endcase
          end
        end else if (ttmr == T_LAST) begin
          // limits were vetted at the floor check, so this step cannot wrap
          now_nx  = (state == MOVE_UP) ? now + 3'd1 : now - 3'd1;
          ttmr_nx = '0;
          fchk_nx = 1'b1;
        end else begin
          ttmr_nx = ttmr + T_ONE;
        end
      end
      DOOR_OPEN: begin
        if (door_hold)       dtmr_nx  = D_LOAD;
        else if (dtmr == '0) state_nx = IDLE;
        else                 dtmr_nx  = dtmr - D_ONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign moving_up   = (state == MOVE_UP);
  assign moving_down = (state == MOVE_DOWN);
  assign door_open   = (state == DOOR_OPEN);

endmodule

// File: doc/car_motion_ctrl.md
CAR_MOTION_CTRL -- requirements
Module: car_motion_ctrl

Interface
REQ-001 SHALL have parameter FLOOR_TICKS, default 4, meaning clock cycles of travel per floor (minimum 2).
REQ-002 SHALL have parameter DOOR_TICKS, default 3, meaning clock cycles the door stays open (minimum 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  a destination is pending; the upstream comparator is driven with it.
REQ-006 SHALL have port result  input  3  comparator output: 3'b100 = des above now, 3'b010 = equal, 3'b001 = des below now.
REQ-007 SHALL have port door_hold  input  1  holds the door open; sampled only in DOOR_OPEN.
REQ-008 SHALL have port now  output  3  current floor, 0..7, registered; feeds the comparator `now` input.
REQ-009 SHALL have port moving_up  output  1  high in MOVE_UP.
REQ-010 SHALL have port moving_down  output  1  high in MOVE_DOWN.
REQ-011 SHALL have port door_open  output  1  high in DOOR_OPEN.
REQ-012 SHALL have port arrived  output  1  one-cycle pulse on entry to DOOR_OPEN.
REQ-013 SHALL have port fault  output  1  one-cycle pulse on illegal result code or a floor-limit violation.

Function
REQ-014 SHALL implement four states: IDLE, MOVE_UP, MOVE_DOWN and DOOR_OPEN, with moving_up, moving_down and door_open decoded from the registered state.
REQ-015 IDLE, req_valid=1, result=100, now<7 SHALL go to MOVE_UP next cycle with travel timer=0.
REQ-016 IDLE, req_valid=1, result=001, now>0 SHALL go to MOVE_DOWN next cycle with travel timer=0.
REQ-017 IDLE, req_valid=1, result=010 SHALL go to DOOR_OPEN next cycle with arrived pulsed.
REQ-018 IDLE with req_valid=0 SHALL remain IDLE regardless of result.
REQ-019 In MOVE_x, the travel timer SHALL count 0..FLOOR_TICKS-1; on the cycle it equals FLOOR_TICKS-1, now SHALL increment (UP) or decrement (DOWN) by 1 and the timer SHALL clear to 0.
REQ-020 In MOVE_x, the result input SHALL be evaluated only when timer==0 and the state was entered or now changed on the previous edge (floor-check cycle).
REQ-021 At a floor-check cycle, result=010 SHALL cause a transition to DOOR_OPEN with arrived pulsed.
REQ-022 At a floor-check cycle, a result matching the current direction SHALL continue the move.
REQ-023 At a floor-check cycle, a result opposite to the current direction SHALL cause a transition to IDLE with no fault.
REQ-024 At a floor-check cycle, req_valid=0 SHALL cause a transition to IDLE (arrival at a floor with no pending request).
REQ-025 MOVE_UP with now==7, or MOVE_DOWN with now==0, at a floor-check cycle, while result still requests the same direction, SHALL go to IDLE and pulse fault; now SHALL never wrap.
REQ-026 IDLE, req_valid=1, result=100 with now==7 (or 001 with now==0) SHALL stay IDLE and pulse fault.
REQ-027 Any result not in {100, 010, 001}, sampled in IDLE with req_valid=1 or at a floor-check cycle, SHALL cause IDLE next cycle and pulse fault; now SHALL be unchanged.
REQ-028 DOOR_OPEN SHALL load the door timer with DOOR_TICKS-1 on entry and decrement it each cycle.
REQ-029 In DOOR_OPEN, door_hold=1 SHALL reload the door timer with DOOR_TICKS-1.
REQ-030 DOOR_OPEN SHALL exit to IDLE on the cycle after the door timer reads 0 with door_hold=0, giving door_open high for exactly DOOR_TICKS cycles when door_hold is never asserted.
REQ-031 now SHALL change only in MOVE_x at the timer terminal count.
REQ-032 arrived and fault SHALL be mutually exclusive and never high for two consecutive cycles from a single event.

Reset
REQ-033 rst=1 at a rising edge SHALL force state=IDLE, now=0, both timers=0, and moving_up, moving_down, door_open, arrived and fault all 0, from any state including mid-travel and mid-door.
REQ-034 rst SHALL take priority over all other inputs; the first non-reset edge SHALL evaluate from IDLE.

Verification
REQ-035 Bench SHALL check: reset, then req_valid=1, result=100 held until now==2, then 010 -> moving_up high; now 0->1 after 4 cycles, 1->2 after 8; arrived pulse at the following floor check; door_open high for 3 cycles; then IDLE.
REQ-036 Bench SHALL check: now=2, result=001, then 010 when now==1 -> MOVE_DOWN; now=1 four cycles later; DOOR_OPEN with arrived.
REQ-037 Bench SHALL check: IDLE, now=6, result=110 (illegal) -> fault pulse for 1 cycle, state IDLE, now=6.
REQ-038 Bench SHALL check: drive up to now=7 with result held at 100 -> fault pulse at the floor-check cycle, now stays 7, IDLE.
REQ-039 Bench SHALL check: DOOR_OPEN with door_hold=1 for 5 cycles, then released -> door_open high for 5+3 cycles.
REQ-040 Bench SHALL check: rst asserted mid-MOVE_UP at now=3 -> next edge now=0, all outputs 0, IDLE.
